// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls,
// EX-resolved redirects, data-memory waits with deferred redirect and timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal flow; load-use, redirect and new memory waits handled
// MEM_WAIT | data memory busy; whole pipe frozen until i_mem_ready
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic [4:0]       i_ex_regd_addr,
    input  logic             i_ex_is_load,
    input  logic             i_ex_jump_en,
    input  logic [31:0]      i_ex_jump_addr,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_pc_stall,
    output logic             o_if_id_stall,
    output logic             o_if_id_flush,
    output logic             o_id_ex_stall,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_stall,
    output logic             o_jump_en,
    output logic [31:0]      o_jump_addr,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic             o_mem_err
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              pend_en, pend_en_nxt;
    logic [31:0]       pend_addr, pend_addr_nxt;
    logic [31:0]       last_addr;
    logic              mem_err, mem_err_nxt;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
    logic              lu_hz, mw, apply_run;
    logic              pc_stall, if_id_stall, if_id_flush;
    logic              id_ex_stall, id_ex_flush, ex_mem_stall, jump_en;
    logic [31:0]       jump_tgt;

    assign lu_hz = i_ex_is_load & (i_ex_regd_addr != 5'd0) &
                   ((i_ex_regd_addr == i_id_rs1_addr) | (i_ex_regd_addr == i_id_rs2_addr));
    assign mw    = i_mem_req & ~i_mem_ready;

    always_comb begin
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        pend_en_nxt   = pend_en;
        pend_addr_nxt = pend_addr;
        mem_err_nxt   = mem_err;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_stall  = 1'b0;
        jump_en       = 1'b0;
        jump_tgt      = last_addr;
        apply_run     = 1'b0;

        case (state)
            RUN: begin
                if (mw) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_nxt     = WAIT_W'(1);
                    if (i_ex_jump_en) begin
                        pend_en_nxt   = 1'b1;
                        pend_addr_nxt = i_ex_jump_addr;
                    end
                end else begin
                    apply_run = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mw) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    if (wait_cnt < WAIT_W'(MEM_TIMEOUT))
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    if (wait_nxt == WAIT_W'(MEM_TIMEOUT))
                        mem_err_nxt = 1'b1;
                end else begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                    // deferred redirect flushes the younger instructions, so lu_hz is moot
                    if (pend_en) begin
                        jump_en     = 1'b1;
                        jump_tgt    = pend_addr;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        pend_en_nxt = 1'b0;
                    end else begin
                        apply_run = 1'b1;
                    end
                end
            end
            default: state_nxt = RUN;
        endcase

        if (apply_run) begin
            if (i_ex_jump_en) begin
                jump_en     = 1'b1;
                jump_tgt    = i_ex_jump_addr;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (lu_hz) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            pend_en   <= 1'b0;
            pend_addr <= '0;
            last_addr <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            pend_en   <= pend_en_nxt;
            pend_addr <= pend_addr_nxt;
            mem_err   <= mem_err_nxt;
            if (jump_en)
                last_addr <= jump_tgt;
            if (pc_stall)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (jump_en)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // strobes are combinational from inputs, so hold them quiet while in reset
    assign o_pc_stall     = pc_stall     & i_rst_n;
    assign o_if_id_stall  = if_id_stall  & i_rst_n;
    assign o_if_id_flush  = if_id_flush  & i_rst_n;
    assign o_id_ex_stall  = id_ex_stall  & i_rst_n;
    assign o_id_ex_flush  = id_ex_flush  & i_rst_n;
    assign o_ex_mem_stall = ex_mem_stall & i_rst_n;
    assign o_jump_en      = jump_en      & i_rst_n;
    assign o_jump_addr    = i_rst_n ? jump_tgt : 32'd0;
    assign o_stall_cnt    = stall_cnt;
    assign o_flush_cnt    = flush_cnt;
    assign o_mem_err      = mem_err;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: per-cycle expected strobes pushed at drive
// time and compared against the DUT at the following falling edge.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic        is_load, jen, req, rdy;
    logic [31:0] jaddr;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, jump_en;
    logic [31:0] jump_addr, stall_cnt, flush_cnt;
    logic        mem_err;

    typedef struct {
        logic [6:0]  strb;
        logic [31:0] addr;
        logic [31:0] scnt;
        logic [31:0] fcnt;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_scnt = 0;
    logic [31:0] exp_fcnt = 0;

    localparam logic [6:0] NONE  = 7'b0000000;
    localparam logic [6:0] ALLST = 7'b1101010;
    localparam logic [6:0] LU    = 7'b1100100;
    localparam logic [6:0] JMP   = 7'b0010101;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2), .i_ex_regd_addr(rd),
        .i_ex_is_load(is_load), .i_ex_jump_en(jen), .i_ex_jump_addr(jaddr),
        .i_mem_req(req), .i_mem_ready(rdy),
        .o_pc_stall(pc_stall), .o_if_id_stall(if_id_stall), .o_if_id_flush(if_id_flush),
        .o_id_ex_stall(id_ex_stall), .o_id_ex_flush(id_ex_flush), .o_ex_mem_stall(ex_mem_stall),
        .o_jump_en(jump_en), .o_jump_addr(jump_addr),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt), .o_mem_err(mem_err)
    );

    function automatic logic [6:0] strobes();
        return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, jump_en};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, pushes the expectation, compares at negedge.
    task automatic step(input string tag,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                        input logic ld, input logic je, input logic [31:0] ja,
                        input logic rq, input logic rd_y,
                        input logic [6:0] strb, input logic [31:0] addr, input logic err);
        exp_t e, got;
        rs1 = s1; rs2 = s2; rd = d; is_load = ld; jen = je; jaddr = ja; req = rq; rdy = rd_y;
        e.strb = strb; e.addr = addr; e.scnt = exp_scnt; e.fcnt = exp_fcnt; e.err = err;
        sb_q.push_back(e);
        if (strb[6]) exp_scnt++;
        if (strb[0]) exp_fcnt++;
        @(negedge clk);
        got = sb_q.pop_front();
        check({tag, "_strb"}, 32'(strobes()), 32'(got.strb));
        check({tag, "_addr"}, jump_addr, got.addr);
        check({tag, "_scnt"}, stall_cnt, got.scnt);
        check({tag, "_fcnt"}, flush_cnt, got.fcnt);
        check({tag, "_err"}, 32'(mem_err), 32'(got.err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rs1 = 0; rs2 = 0; rd = 0; is_load = 0; jen = 0; jaddr = 0; req = 0; rdy = 0;
        @(posedge clk);
        #1;
        check("rst_strb", 32'(strobes()), 32'(NONE));
        check("rst_addr", jump_addr, 32'h0);
        check("rst_cnt", stall_cnt | flush_cnt, 32'h0);
        check("rst_err", 32'(mem_err), 32'h0);
        rst_n = 1'b1;

        //    tag       rs1 rs2 rd ld je addr      rq rdy  strb   exp addr    err
        step("idle",     0,  0,  0, 0, 0, 32'h0,   0, 0,   NONE,  32'h0,      0);
        step("lu_rs2",   3,  5,  5, 1, 0, 32'h0,   0, 0,   LU,    32'h0,      0);
        step("lu_gone",  3,  5,  0, 0, 0, 32'h0,   0, 0,   NONE,  32'h0,      0);
        step("x0_load",  0,  4,  0, 1, 0, 32'h0,   0, 0,   NONE,  32'h0,      0);
        step("alu_fwd",  7,  7,  7, 0, 0, 32'h0,   0, 0,   NONE,  32'h0,      0);
        step("lu_rs1",   9,  2,  9, 1, 0, 32'h0,   0, 0,   LU,    32'h0,      0);
        step("branch",   0,  0,  0, 0, 1, 32'h40,  0, 0,   JMP,   32'h40,     0);
        step("hold_a",   0,  0,  0, 0, 0, 32'h99,  0, 0,   NONE,  32'h40,     0);
        step("jmp_lu",   5,  0,  5, 1, 1, 32'h44,  0, 0,   JMP,   32'h44,     0);
        step("hold_b",   0,  0,  0, 0, 0, 32'h0,   0, 0,   NONE,  32'h44,     0);
        // redirect arriving while memory is busy is deferred until ready
        step("mw_jmp",   0,  0,  0, 0, 1, 32'h80,  1, 0,   ALLST, 32'h44,     0);
        step("mw_2",     0,  0,  0, 0, 0, 32'h0,   1, 0,   ALLST, 32'h44,     0);
        step("mw_3",     0,  0,  0, 0, 0, 32'h0,   1, 0,   ALLST, 32'h44,     0);
        step("mw_pend",  5,  0,  5, 1, 0, 32'h0,   1, 1,   JMP,   32'h80,     0);
        step("mw_after", 0,  0,  0, 0, 0, 32'h0,   0, 0,   NONE,  32'h80,     0);
        step("mw_nopd",  0,  0,  0, 0, 0, 32'h0,   1, 0,   ALLST, 32'h80,     0);
        step("mw_exlu",  6,  0,  6, 1, 0, 32'h0,   1, 1,   LU,    32'h80,     0);
        step("idle2",    0,  0,  0, 0, 0, 32'h0,   0, 0,   NONE,  32'h80,     0);
        // timeout: four wait cycles complete before the error is visible
        step("to_1",     0,  0,  0, 0, 0, 32'h0,   1, 0,   ALLST, 32'h80,     0);
        step("to_2",     0,  0,  0, 0, 0, 32'h0,   1, 0,   ALLST, 32'h80,     0);
        step("to_3",     0,  0,  0, 0, 0, 32'h0,   1, 0,   ALLST, 32'h80,     0);
        step("to_4",     0,  0,  0, 0, 0, 32'h0,   1, 0,   ALLST, 32'h80,     0);
        step("to_5",     0,  0,  0, 0, 0, 32'h0,   1, 0,   ALLST, 32'h80,     1);
        step("to_6",     0,  0,  0, 0, 0, 32'h0,   1, 0,   ALLST, 32'h80,     1);
        step("to_rdy",   0,  0,  0, 0, 0, 32'h0,   1, 1,   NONE,  32'h80,     1);
        step("to_stky",  0,  0,  0, 0, 0, 32'h0,   0, 0,   NONE,  32'h80,     1);
        step("rw_jmp",   0,  0,  0, 0, 1, 32'hC0,  1, 0,   ALLST, 32'h80,     1);
        step("rw_2",     0,  0,  0, 0, 0, 32'h0,   1, 0,   ALLST, 32'h80,     1);

        // asynchronous reset in MEM_WAIT with a pending redirect
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_strb", 32'(strobes()), 32'(NONE));
        check("arst_addr", jump_addr, 32'h0);
        check("arst_scnt", stall_cnt, 32'h0);
        check("arst_fcnt", flush_cnt, 32'h0);
        check("arst_err", 32'(mem_err), 32'h0);
        req = 0; rdy = 0; jen = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_scnt = 0;
        exp_fcnt = 0;
        step("post_1",   0,  0,  0, 0, 0, 32'h0,   0, 0,   NONE,  32'h0,      0);
        step("post_rdy", 0,  0,  0, 0, 0, 32'h0,   1, 1,   NONE,  32'h0,      0);
        step("post_2",   0,  0,  0, 0, 0, 32'h0,   0, 0,   NONE,  32'h0,      0);

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
